chacha20_poly1305_aead_fmt: RTL and testbench

Sequencer between the data path and the Poly1305 block engine of the ChaCha20-Poly1305 core. It takes AAD and ciphertext blocks, zero-pads each segment to 16 bytes, and counts bytes per segment. It then appends the RFC 8439 length block (aad_len || ct_len, 64-bit LE each). When the Poly1305 tag returns, it does a constant-time comparison against an expected tag to produce tag_correct.

---
 rtl/chacha20_poly1305_aead_fmt_pkg.sv | 25 ++
 rtl/chacha20_poly1305_aead_fmt_if.sv | 34 +++
 rtl/chacha20_poly1305_aead_fmt_tag_cmp.sv | 19 +
 rtl/chacha20_poly1305_aead_fmt.sv | 229 ++++++++++++++++++++++
 tb/tb_chacha20_poly1305_aead_fmt.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha20_poly1305_aead_fmt_pkg.sv
// Shared definitions for the ChaCha20-Poly1305 AEAD block formatter:
// sequencer state encoding, block geometry and length-block layout.
package chacha20_poly1305_pkg;

    // Sequencer states, in the order a message walks through them.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_AAD      = 3'd1,
        S_CT       = 3'd2,
        S_LEN      = 3'd3,
        S_WAIT_TAG = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    // One Poly1305 block is 16 bytes; byte counts 0..16 need 5 bits.
    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_CNT_W  = 5;
    localparam int BLOCK_W     = 8 * BLOCK_BYTES;

    // Byte offsets of the two 64-bit little-endian lengths in the final block.
    localparam int LEN_AAD_OFS = 0;
    localparam int LEN_CT_OFS  = 8;

endpackage

// File: rtl/chacha20_poly1305_aead_fmt_if.sv
// Block streams around the formatter: the input stream (AAD/CT blocks in)
// and the Poly1305 stream (padded blocks and the length block out).
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised, it and its payload stay unchanged
// until that transfer; ready may change freely and never waits on anything
// else from the same side.
interface chacha20_poly1305_aead_fmt_if;
    import chacha20_poly1305_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [BLOCK_W-1:0]    in_data;
    logic [BYTE_CNT_W-1:0] in_bytes;
    logic                  in_last;

    logic                  blk_valid;
    logic                  blk_ready;
    logic [BLOCK_W-1:0]    blk_data;
    logic                  blk_final;

    // Surrounding data path / Poly1305 engine side.
    modport master (
        output in_valid, in_data, in_bytes, in_last, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_final
    );

    // Formatter side.
    modport slave (
        input  in_valid, in_data, in_bytes, in_last, blk_ready,
        output in_ready, blk_valid, blk_data, blk_final
    );

endinterface

// File: rtl/chacha20_poly1305_aead_fmt_tag_cmp.sv
// Constant-time 128-bit tag equality: every bit difference feeds one
// XOR/OR reduction so the result never depends on where tags differ.
module chacha20_poly1305_tag_cmp
    import chacha20_poly1305_pkg::*;
(
    input  logic [BLOCK_W-1:0] tag_a_i,
    input  logic [BLOCK_W-1:0] tag_b_i,
    output logic               equal_o
);

    logic [BLOCK_W-1:0] diff;

    // Bitwise difference, then a full OR tree over all bits.
    always_comb begin
        diff    = tag_a_i ^ tag_b_i;
        equal_o = ~|diff;
    end

endmodule

// File: rtl/chacha20_poly1305_aead_fmt.sv
// ChaCha20-Poly1305 AEAD formatter: zero-pads AAD and ciphertext segments
// into 16-byte Poly1305 blocks, counts segment bytes, appends the
// aad_len || ct_len block and checks the returned tag against the expected one.
module chacha20_poly1305_aead_fmt
    import chacha20_poly1305_pkg::*;
#(
    parameter int LEN_W     = 64,
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        verify,
    chacha20_poly1305_aead_fmt_if.slave bus,
    input  logic                        tag_valid,
    input  logic [BLOCK_W-1:0]          p1305_tag_in,
    input  logic [BLOCK_W-1:0]          expected_tag,
    output logic [BLOCK_W-1:0]          p1305_tag,
    output logic                        tag_correct,
    output logic                        done,
    output logic                        error,
    output state_t                      dbg_state_o
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   aad_len_q, aad_len_d;
    logic [LEN_W-1:0]   ct_len_q, ct_len_d;
    logic               verify_q, verify_d;
    logic               blk_valid_q, blk_valid_d;
    logic               blk_final_q, blk_final_d;
    logic [BLOCK_W-1:0] blk_data_q, blk_data_d;
    logic [BLOCK_W-1:0] tag_q, tag_d;
    logic               tag_correct_q, tag_correct_d;
    logic               error_q, error_d;

    logic               out_free;
    logic               in_ready;
    logic               accept;
    logic [LEN_W-1:0]   seg_cnt;
    logic [LEN_W:0]     seg_sum;
    logic               beat_bad;
    logic [BLOCK_W-1:0] padded;
    logic [BLOCK_W-1:0] len_block;
    logic               tag_eq;

    // The comparator only exists when verification is built in.
    generate
        if (VERIFY_EN) begin : g_cmp
            chacha20_poly1305_tag_cmp u_tag_cmp (
                .tag_a_i (p1305_tag_in),
                .tag_b_i (expected_tag),
                .equal_o (tag_eq)
            );
        end else begin : g_no_cmp
            assign tag_eq = 1'b0;
        end
    endgenerate

    // Input acceptance: only while streaming a segment and the single
    // output register is empty or being drained this cycle.
    always_comb begin
        out_free = !blk_valid_q || bus.blk_ready;
        in_ready = ((state_q == S_AAD) || (state_q == S_CT)) && out_free;
        accept   = bus.in_valid && in_ready;
    end

    // Byte accounting for the current segment and protocol checks on a beat:
    // short blocks only at segment end, at most 16 bytes, no counter wrap.
    always_comb begin
        seg_cnt  = (state_q == S_CT) ? ct_len_q : aad_len_q;
        seg_sum  = {1'b0, seg_cnt} + (LEN_W + 1)'(bus.in_bytes);
        beat_bad = (bus.in_bytes > BYTE_CNT_W'(BLOCK_BYTES))
                || ((bus.in_bytes != BYTE_CNT_W'(BLOCK_BYTES)) && !bus.in_last)
                || seg_sum[LEN_W];
    end

    // Zero every byte at or above in_bytes.
    always_comb begin
        padded = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (BYTE_CNT_W'(i) < bus.in_bytes) begin
                padded[8*i +: 8] = bus.in_data[8*i +: 8];
            end
        end
    end

    // Length block: two little-endian 64-bit byte counts, zero-extended.
    always_comb begin
        len_block = '0;
        len_block[8*LEN_AAD_OFS +: 64] = 64'(aad_len_q);
        len_block[8*LEN_CT_OFS  +: 64] = 64'(ct_len_q);
    end

    // Next-state and register-update logic for the message sequencer.
    always_comb begin
        state_d       = state_q;
        aad_len_d     = aad_len_q;
        ct_len_d      = ct_len_q;
        verify_d      = verify_q;
        blk_valid_d   = blk_valid_q;
        blk_final_d   = blk_final_q;
        blk_data_d    = blk_data_q;
        tag_d         = tag_q;
        tag_correct_d = tag_correct_q;
        error_d       = error_q;

        // A block leaving this cycle empties the output register unless
        // something below reloads it.
        if (blk_valid_q && bus.blk_ready) begin
            blk_valid_d = 1'b0;
            blk_final_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                if (state_q == S_ERR) begin
                    blk_valid_d = 1'b0;
                    blk_final_d = 1'b0;
                end
                if (start) begin
                    state_d       = S_AAD;
                    aad_len_d     = '0;
                    ct_len_d      = '0;
                    error_d       = 1'b0;
                    tag_correct_d = 1'b0;
                    verify_d      = verify;
                end
            end

            S_AAD, S_CT: begin
                if (accept) begin
                    if (beat_bad) begin
                        // The faulty beat is dropped; the previous block (if
                        // any) has already been handed off this same cycle.
                        state_d     = S_ERR;
                        error_d     = 1'b1;
                        blk_valid_d = 1'b0;
                        blk_final_d = 1'b0;
                    end else begin
                        if (state_q == S_CT) begin
                            ct_len_d = seg_sum[LEN_W-1:0];
                        end else begin
                            aad_len_d = seg_sum[LEN_W-1:0];
                        end
                        // An empty segment only closes the segment.
                        if (bus.in_bytes != '0) begin
                            blk_valid_d = 1'b1;
                            blk_final_d = 1'b0;
                            blk_data_d  = padded;
                        end
                        if (bus.in_last) begin
                            state_d = (state_q == S_AAD) ? S_CT : S_LEN;
                        end
                    end
                end
            end

            S_LEN: begin
                if (blk_valid_q && blk_final_q) begin
                    if (bus.blk_ready) begin
                        state_d = S_WAIT_TAG;
                    end
                end else if (out_free) begin
                    // Last ciphertext block gone (or going): load the lengths.
                    blk_valid_d = 1'b1;
                    blk_final_d = 1'b1;
                    blk_data_d  = len_block;
                end
            end

            S_WAIT_TAG: begin
                if (tag_valid) begin
                    tag_d         = p1305_tag_in;
                    tag_correct_d = verify_q && tag_eq;
                    state_d       = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            aad_len_q     <= '0;
            ct_len_q      <= '0;
            verify_q      <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_final_q   <= 1'b0;
            blk_data_q    <= '0;
            tag_q         <= '0;
            tag_correct_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            aad_len_q     <= aad_len_d;
            ct_len_q      <= ct_len_d;
            verify_q      <= verify_d;
            blk_valid_q   <= blk_valid_d;
            blk_final_q   <= blk_final_d;
            blk_data_q    <= blk_data_d;
            tag_q         <= tag_d;
            tag_correct_q <= tag_correct_d;
            error_q       <= error_d;
        end
    end

    // Output mapping.
    always_comb begin
        bus.in_ready  = in_ready;
        bus.blk_valid = blk_valid_q;
        bus.blk_data  = blk_data_q;
        bus.blk_final = blk_final_q;
        p1305_tag     = tag_q;
        tag_correct   = tag_correct_q;
        done          = (state_q == S_DONE);
        error         = error_q;
        dbg_state_o   = state_q;
    end

endmodule

// File: tb/tb_chacha20_poly1305_aead_fmt.sv
// Directed bench for the AEAD formatter: RFC 8439 2.8.2 message, wrong tags,
// empty AAD, verify off, back-pressure, protocol error and mid-message reset.
module tb_chacha20_poly1305_aead_fmt;
    import chacha20_poly1305_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic         verify = 1'b0;
    logic         tag_valid = 1'b0;
    logic [127:0] p1305_tag_in = '0;
    logic [127:0] expected_tag = '0;
    logic [127:0] p1305_tag;
    logic         tag_correct;
    logic         done;
    logic         error;
    state_t       dbg_state;

    chacha20_poly1305_aead_fmt_if bus_if ();

    chacha20_poly1305_aead_fmt #(.LEN_W(64), .VERIFY_EN(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .verify       (verify),
        .bus          (bus_if),
        .tag_valid    (tag_valid),
        .p1305_tag_in (p1305_tag_in),
        .expected_tag (expected_tag),
        .p1305_tag    (p1305_tag),
        .tag_correct  (tag_correct),
        .done         (done),
        .error        (error),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- vectors ----------------
    logic [7:0] aad_b [12] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'hc0, 8'hc1, 8'hc2, 8'hc3,
                               8'hc4, 8'hc5, 8'hc6, 8'hc7};
    logic [7:0] ct_b [114] = '{
        8'hd3, 8'h1a, 8'h8d, 8'h34, 8'h64, 8'h8e, 8'h60, 8'hdb, 8'h7b, 8'h86, 8'haf, 8'hbc, 8'h53, 8'hef, 8'h7e, 8'hc2,
        8'ha4, 8'had, 8'hed, 8'h51, 8'h29, 8'h6e, 8'h08, 8'hfe, 8'ha9, 8'he2, 8'hb5, 8'ha7, 8'h36, 8'hee, 8'h62, 8'hd6,
        8'h3d, 8'hbe, 8'ha4, 8'h5e, 8'h8c, 8'ha9, 8'h67, 8'h12, 8'h82, 8'hfa, 8'hfb, 8'h69, 8'hda, 8'h92, 8'h72, 8'h8b,
        8'h1a, 8'h71, 8'hde, 8'h0a, 8'h9e, 8'h06, 8'h0b, 8'h29, 8'h05, 8'hd6, 8'ha5, 8'hb6, 8'h7e, 8'hcd, 8'h3b, 8'h36,
        8'h92, 8'hdd, 8'hbd, 8'h7f, 8'h2d, 8'h77, 8'h8b, 8'h8c, 8'h98, 8'h03, 8'hae, 8'he3, 8'h28, 8'h09, 8'h1b, 8'h58,
        8'hfa, 8'hb3, 8'h24, 8'he4, 8'hfa, 8'hd6, 8'h75, 8'h94, 8'h55, 8'h85, 8'h80, 8'h8b, 8'h48, 8'h31, 8'hd7, 8'hbc,
        8'h3f, 8'hf4, 8'hde, 8'hf0, 8'h8e, 8'h4b, 8'h7a, 8'h9d, 8'he5, 8'h76, 8'hd2, 8'h65, 8'h86, 8'hce, 8'hc6, 8'h4b,
        8'h61, 8'h16};

    // Tag 1ae10b594f09e26a7e902ecbd0600691 with byte 0 in bits [7:0].
    localparam logic [127:0] RFC_TAG   = 128'h910660d0cb2e907e6ae2094f590be11a;
    localparam logic [127:0] LEN_RFC   = 128'h0000000000000072_000000000000000c;
    localparam logic [127:0] LEN_E32   = 128'h0000000000000020_0000000000000000;
    localparam logic [127:0] LEN_12_32 = 128'h0000000000000020_000000000000000c;

    // ---------------- scoreboard ----------------
    logic [128:0] exp_q[$];      // {blk_final, blk_data}
    logic [129:0] tag_exp_q[$];  // {error, tag_correct, p1305_tag}
    int n_vec = 0;
    int n_err = 0;
    int blk_seen = 0;
    bit stall_en = 1'b0;
    int stall_cnt = 0;

    task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, {bus_if.in_ready, bus_if.blk_valid, bus_if.blk_final,
                               done, error, tag_correct}, '0);
        check({name, "_blk_data"}, {2'b00, bus_if.blk_data}, '0);
        check({name, "_tag"}, {2'b00, p1305_tag}, '0);
    endtask

    // Monitor: compares every transferred block and every done pulse.
    initial begin
        logic [128:0] e;
        logic [129:0] t;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus_if.blk_valid && bus_if.blk_ready) begin
                    blk_seen++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL blk_unexpected: got %h, want no block",
                                 {bus_if.blk_final, bus_if.blk_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("blk", {1'b0, bus_if.blk_final, bus_if.blk_data}, {1'b0, e});
                    end
                end else if (bus_if.blk_valid) begin
                    check("stall_in_ready", bus_if.in_ready, 0);
                    if (exp_q.size() != 0) begin
                        check("stall_hold", {1'b0, bus_if.blk_final, bus_if.blk_data}, {1'b0, exp_q[0]});
                    end
                end
                if (done) begin
                    if (tag_exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL done_unexpected: got done=1, want done=0");
                    end else begin
                        t = tag_exp_q.pop_front();
                        check("tag", {error, tag_correct, p1305_tag}, t);
                    end
                end
            end
        end
    end

    // Poly1305-side ready: always high, or held low 5 cycles per block.
    initial begin
        bus_if.blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_en) begin
                bus_if.blk_ready = 1'b1;
                stall_cnt = 0;
            end else if (bus_if.blk_ready) begin
                bus_if.blk_ready = 1'b0;
            end else if (bus_if.blk_valid) begin
                stall_cnt++;
                if (stall_cnt == 5) begin
                    bus_if.blk_ready = 1'b1;
                    stall_cnt = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [7:0] get_byte(input bit is_ct, input int idx);
        return is_ct ? ct_b[idx] : aad_b[idx];
    endfunction

    task automatic start_msg(input bit v, input logic [127:0] etag);
        @(posedge clk);
        #1;
        start = 1'b1;
        verify = v;
        expected_tag = etag;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present one beat and wait (bounded) for it to be taken.
    task automatic beat(input logic [127:0] d, input logic [4:0] nb, input logic last,
                        input logic [128:0] exp, input bit push);
        bit ok;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        bus_if.in_bytes = nb;
        bus_if.in_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("beat_accept", ok, 1);
        if (ok && push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Send a segment as 16-byte beats (garbage beyond the valid bytes).
    task automatic send_seg(input bit is_ct, input int len, input int max_blocks);
        logic [127:0] raw;
        logic [127:0] msk;
        int off;
        int n;
        int nb;
        if (len == 0) begin
            beat('0, 5'd0, 1'b1, '0, 1'b0);
        end else begin
            off = 0;
            nb = 0;
            while (off < len && nb < max_blocks) begin
                n = (len - off > 16) ? 16 : len - off;
                for (int j = 0; j < 16; j++) begin
                    if (j < n) begin
                        raw[8*j +: 8] = get_byte(is_ct, off + j);
                        msk[8*j +: 8] = get_byte(is_ct, off + j);
                    end else begin
                        raw[8*j +: 8] = 8'($urandom_range(1, 255));
                        msk[8*j +: 8] = 8'h00;
                    end
                end
                beat(raw, 5'(n), (off + n == len), {1'b0, msk}, 1'b1);
                off += n;
                nb++;
            end
        end
    endtask

    task automatic run_msg(input int aad_n, input int ct_n, input bit v,
                           input logic [127:0] tag_in, input logic [127:0] etag,
                           input bit exp_ok, input logic [127:0] exp_len, input int exp_blocks);
        int base;
        int lat;
        bit seen;
        start_msg(v, etag);
        base = blk_seen;
        send_seg(1'b0, aad_n, 1000);
        send_seg(1'b1, ct_n, 1000);
        exp_q.push_back({1'b1, exp_len});
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus_if.blk_valid && bus_if.blk_ready && bus_if.blk_final) begin
                seen = 1'b1;
                break;
            end
        end
        check("len_block_seen", seen, 1);
        @(posedge clk);
        #1;
        tag_exp_q.push_back({1'b0, exp_ok, tag_in});
        tag_valid = 1'b1;
        p1305_tag_in = tag_in;
        @(posedge clk);
        #1;
        tag_valid = 1'b0;
        lat = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) begin
                lat = t;
                break;
            end
        end
        check("tag_to_done_wait", 130'(lat), 0);
        check("block_count", 130'(blk_seen - base), 130'(exp_blocks));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] flip;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.in_bytes = '0;
        bus_if.in_last  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        check("reset_state", dbg_state, S_IDLE);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // RFC 8439 2.8.2: 1 AAD + 8 CT + length block.
        run_msg(12, 114, 1'b1, RFC_TAG, RFC_TAG, 1'b1, LEN_RFC, 10);

        // Wrong expected tag, top bit then bottom bit.
        flip = '0;
        flip[127] = 1'b1;
        run_msg(12, 114, 1'b1, RFC_TAG, RFC_TAG ^ flip, 1'b0, LEN_RFC, 10);
        flip = '0;
        flip[0] = 1'b1;
        run_msg(12, 114, 1'b1, RFC_TAG, RFC_TAG ^ flip, 1'b0, LEN_RFC, 10);

        // Empty AAD, 32-byte CT.
        run_msg(0, 32, 1'b1, RFC_TAG, RFC_TAG, 1'b1, LEN_E32, 3);

        // Matching tag but encrypt mode: no tag_correct.
        run_msg(12, 32, 1'b0, RFC_TAG, RFC_TAG, 1'b0, LEN_12_32, 4);

        // Back-pressure on every block.
        stall_en = 1'b1;
        run_msg(12, 114, 1'b1, RFC_TAG, RFC_TAG, 1'b1, LEN_RFC, 10);
        stall_en = 1'b0;
        repeat (3) @(posedge clk);

        // Short CT block without in_last: error, then a clean restart.
        start_msg(1'b1, RFC_TAG);
        send_seg(1'b0, 12, 1000);
        beat(128'h00000000000000000011223344556677, 5'd7, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("err_ctl", {error, bus_if.blk_valid, bus_if.in_ready}, 3'b100);
        check("err_state", dbg_state, S_ERR);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("err_sticky", {error, bus_if.blk_valid}, 2'b10);
        run_msg(12, 114, 1'b1, RFC_TAG, RFC_TAG, 1'b1, LEN_RFC, 10);

        // Asynchronous reset in the middle of the ciphertext.
        start_msg(1'b1, RFC_TAG);
        send_seg(1'b0, 12, 1000);
        send_seg(1'b1, 114, 3);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b1;
        bus_if.in_bytes = 5'd16;
        bus_if.in_last  = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        check("mid_reset_state", dbg_state, S_IDLE);
        bus_if.in_valid = 1'b0;
        check("mid_reset_queue", 130'(exp_q.size()), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_msg(12, 114, 1'b1, RFC_TAG, RFC_TAG, 1'b1, LEN_RFC, 10);

        repeat (4) @(posedge clk);
        check("blk_queue_drained", 130'(exp_q.size()), 0);
        check("tag_queue_drained", 130'(tag_exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #300000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
